// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: PC control, ROM read port and decoder handshake.
// The master modport is the fetch unit's view; slave is the surrounding system.
interface fetch_if;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        flush;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        input  pc_addr, flush, rom_ack, rom_data, instr_ready,
        output pc_inc, rom_addr, rom_req, instr, instr_pc, instr_valid
    );

    modport slave (
        output pc_addr, flush, rom_ack, rom_data, instr_ready,
        input  pc_inc, rom_addr, rom_req, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding ROM read at a time, results queued in a
// small FIFO for the decoder; jumps flush the queue and drop in-flight reads.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    fetch_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic [15:0]             addr_q, addr_d;
    logic [AW:0]             count_q, count_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0][31:0]  buf_q;
    logic                    issue, push, pop;

    // Reset is folded in so the PC never advances while the block is held in reset.
    assign issue = rst_ni && (state_q == IDLE) && (count_q < FULL) && !bus.flush;
    assign pop   = (count_q != '0) && bus.instr_ready && !bus.flush;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = bus.pc_addr;
                end
            end
            REQ: begin
                if (bus.rom_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    push    = !bus.flush;
                end else if (bus.flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.rom_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (bus.flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) buf_q[wr_ptr_q] <= {bus.rom_data, addr_q};
        end
    end

    assign bus.pc_inc      = issue;
    assign bus.rom_req     = req_q;
    assign bus.rom_addr    = addr_q;
    assign bus.instr       = buf_q[rd_ptr_q][31:16];
    assign bus.instr_pc    = buf_q[rd_ptr_q][15:0];
    assign bus.instr_valid = (count_q != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM responder with programmable latency, a PC
// model driven by PC_INC/FLUSH, and a scoreboard queue of expected words.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic        req_out = 1'b0;
    logic        stale   = 1'b0;
    logic [15:0] pend    = '0;
    logic [15:0] target  = '0;
    logic [15:0] first_pc = '0;
    logic [15:0] saved_pc;
    int          lat = 0;
    int          wcnt = 0;
    int          n_pop = 0;
    int          run = 0;
    int          max_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic inc_s, req_s, ack_s, fl_s, v_s, rdy_s, exp_inc;
        logic [15:0] a_s, i_s, ip_s;
        @(negedge clk);
        inc_s = bus.pc_inc;   req_s = bus.rom_req;  ack_s = bus.rom_ack;
        fl_s  = bus.flush;    v_s   = bus.instr_valid; rdy_s = bus.instr_ready;
        a_s   = bus.rom_addr; i_s   = bus.instr;    ip_s  = bus.instr_pc;
        exp_inc = 1'b0;
        if (!rst_n) begin
            sb.delete();
            req_out = 1'b0;
            stale   = 1'b0;
        end else begin
            exp_inc = !req_out && (sb.size() < DEPTH) && !fl_s;
            chk("pc_inc", inc_s, exp_inc);
            chk("rom_req", req_s, req_out);
            if (req_out) chk("rom_addr", a_s, pend);
            chk("instr_valid", v_s, sb.size() != 0);
            if (v_s && sb.size() != 0) begin
                chk("instr_head", {i_s, ip_s}, sb[0]);
                if (rdy_s && !fl_s) begin
                    void'(sb.pop_front());
                    n_pop++;
                    if (n_pop == 1) first_pc = ip_s;
                end
            end
            if (req_s) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (ack_s && req_out) begin
                if (!stale && !fl_s) sb.push_back({pend ^ 16'hA500, pend});
                req_out = 1'b0;
                stale   = 1'b0;
            end else if (fl_s && req_out) begin
                stale = 1'b1;
            end
            if (fl_s) sb.delete();
            if (exp_inc) begin
                req_out = 1'b1;
                pend    = bus.pc_addr;
            end
        end
        @(posedge clk);
        #1;
        if (fl_s)       bus.pc_addr = target;
        else if (inc_s) bus.pc_addr = bus.pc_addr + 16'd1;
        if (!rst_n) begin
            bus.rom_ack = 1'b0;
            wcnt = 0;
        end else begin
            bus.rom_ack  = bus.rom_req && (wcnt >= lat);
            bus.rom_data = bus.rom_addr ^ 16'hA500;
            if (bus.rom_req) wcnt++; else wcnt = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_req"},  bus.rom_req, 1'b0);
        chk({tag, "_rom_addr"}, bus.rom_addr, 16'h0);
        chk({tag, "_valid"},    bus.instr_valid, 1'b0);
        chk({tag, "_instr"},    bus.instr, 16'h0);
        chk({tag, "_instr_pc"}, bus.instr_pc, 16'h0);
        chk({tag, "_pc_inc"},   bus.pc_inc, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pc_addr = 16'h0; bus.flush = 1'b0; bus.rom_ack = 1'b0;
        bus.rom_data = 16'h0; bus.instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Zero-wait streaming: A500, A501, ... one word every two cycles.
        lat = 0;
        n_pop = 0;
        repeat (6) cycle();
        chk("stream_pc", bus.pc_addr, 16'd3);
        chk("stream_pops", n_pop, 2);
        chk("stream_first_pc", first_pc, 16'h0);

        // Decoder stalled: buffer fills, no further issue.
        bus.instr_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_pc", bus.pc_addr, 16'd4);
        chk("stall_req", bus.rom_req, 1'b0);
        chk("stall_valid", bus.instr_valid, 1'b1);
        bus.instr_ready = 1'b1;
        repeat (8) cycle();

        // Slow ROM: request held for the whole wait.
        lat = 5;
        max_run = 0;
        run = 0;
        repeat (16) cycle();
        chk("slow_req_run", max_run, 6);

        // Flush with a word buffered and a read in flight.
        bus.instr_ready = 1'b0;
        lat = 3;
        for (int i = 0; i < 30 && !(req_out && sb.size() == 1 && !bus.rom_ack); i++) cycle();
        chk("tmo_flush_setup", req_out && sb.size() == 1, 1'b1);
        bus.flush = 1'b1; target = 16'h0100;
        cycle();
        bus.flush = 1'b0;
        chk("flush_valid", bus.instr_valid, 1'b0);
        chk("flush_pc", bus.pc_addr, 16'h0100);
        bus.instr_ready = 1'b1;
        n_pop = 0;
        repeat (14) cycle();
        chk("flush_first_pc", first_pc, 16'h0100);

        // Flush coincident with an ACK.
        lat = 0;
        for (int i = 0; i < 30 && !(bus.rom_ack && req_out && !stale); i++) cycle();
        chk("tmo_ack_flush", bus.rom_ack && req_out, 1'b1);
        bus.flush = 1'b1; target = 16'h0200;
        cycle();
        bus.flush = 1'b0;
        n_pop = 0;
        repeat (8) cycle();
        chk("ackflush_first_pc", first_pc, 16'h0200);

        // Flush in an issue-eligible idle cycle.
        for (int i = 0; i < 30 && req_out; i++) cycle();
        chk("tmo_idle_flush", req_out, 1'b0);
        bus.flush = 1'b1; target = 16'h0300;
        cycle();
        bus.flush = 1'b0;
        chk("idleflush_pc", bus.pc_addr, 16'h0300);
        n_pop = 0;
        repeat (8) cycle();
        chk("idleflush_first_pc", first_pc, 16'h0300);

        // Reset pulse mid-request with data buffered; late ACK ignored.
        bus.instr_ready = 1'b0;
        lat = 3;
        for (int i = 0; i < 30 && !(req_out && sb.size() >= 1 && !bus.rom_ack); i++) cycle();
        chk("tmo_rst_setup", req_out && sb.size() >= 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cycle();
        rst_n = 1'b1;
        bus.rom_ack = 1'b1;
        saved_pc = bus.pc_addr;
        cycle();
        chk("rst_refetch_addr", bus.rom_addr, saved_pc);
        chk("rst_refetch_req", bus.rom_req, 1'b1);
        bus.instr_ready = 1'b1;
        n_pop = 0;
        repeat (10) cycle();
        chk("rst_first_pc", first_pc, saved_pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
